// File: rtl/command_token_encoder_if.sv
// Request, token and FIFO-write bundle between the host side and the command token encoder.
// The encoder connects through the slave modport; the host/bench side uses master.
interface command_token_encoder_if #(
  parameter int word_size = 16
);
  logic                 req_valid;
  logic                 req_ready;
  logic [7:0]           req_instr;
  logic [2:0]           req_a;
  logic [4:0]           req_arg2;
  logic                 tok_valid;
  logic                 tok_ready;
  logic [word_size-1:0] tok_data;
  logic [word_size-1:0] pop_data;
  logic [word_size-1:0] pop_command;
  logic                 wr_en_data;
  logic [word_size-1:0] data_out_data;
  logic                 wr_en_command;
  logic [word_size-1:0] data_out_command;
  logic                 busy;
  logic                 done;
  logic                 err_opcode;

  modport master (
    output req_valid, req_instr, req_a, req_arg2, tok_valid, tok_data, pop_data, pop_command,
    input  req_ready, tok_ready, wr_en_data, data_out_data, wr_en_command, data_out_command,
    input  busy, done, err_opcode
  );

  modport slave (
    input  req_valid, req_instr, req_a, req_arg2, tok_valid, tok_data, pop_data, pop_command,
    output req_ready, tok_ready, wr_en_data, data_out_data, wr_en_command, data_out_command,
    output busy, done, err_opcode
  );
endinterface

// File: rtl/command_token_encoder.sv
// Writes an instruction's data tokens, then its packed command word, into the accelerator
// input FIFOs; an instruction only starts once both FIFOs have room for all of it.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// CHECK | opcode check and FIFO free-space wait
// DATA  | accepting data tokens until the counter reaches 0
// CMD   | command word write cycle
// DONE  | done pulse, back to IDLE
module command_token_encoder #(
  parameter int word_size   = 16,
  parameter int buffer_size = 1024
) (
  input logic clk,
  input logic rst,
  command_token_encoder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CHECK, DATA, CMD, DONE} state_t;

  localparam logic [word_size:0] BUF_SZ = (word_size+1)'(buffer_size);

  state_t               state_q;
  logic [7:0]           instr_q;
  logic [2:0]           a_q;
  logic [4:0]           arg2_q;
  logic [5:0]           cnt_q;
  logic                 wr_data_q;
  logic [word_size-1:0] dout_data_q;
  logic                 wr_cmd_q;
  logic [word_size-1:0] dout_cmd_q;
  logic                 done_q;
  logic                 err_q;

  logic [5:0]           k_d;
  logic [word_size:0]   free_data;
  logic [word_size:0]   free_cmd;
  logic                 space_ok;
  logic [word_size-1:0] cmd_word;

  always_comb begin
    k_d = 6'd0;
    case (bus.req_instr)
      8'd0:    k_d = {1'b0, bus.req_arg2} + 6'd1;
      8'd1:    k_d = 6'd1;
      8'd2:    k_d = {1'b0, bus.req_arg2};
      default: k_d = 6'd0;
    endcase
  end

  // Unsigned at word_size+1 bits so buffer_size itself is representable.
  assign free_data = BUF_SZ - {1'b0, bus.pop_data};
  assign free_cmd  = BUF_SZ - {1'b0, bus.pop_command};
  assign space_ok  = (free_data >= (word_size+1)'(cnt_q)) && (free_cmd >= (word_size+1)'(1));
  assign cmd_word  = word_size'({arg2_q, a_q, instr_q});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      a_q         <= '0;
      arg2_q      <= '0;
      cnt_q       <= '0;
      wr_data_q   <= 1'b0;
      dout_data_q <= '0;
      wr_cmd_q    <= 1'b0;
      dout_cmd_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wr_data_q <= 1'b0;
      wr_cmd_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            instr_q <= bus.req_instr;
            a_q     <= bus.req_a;
            arg2_q  <= bus.req_arg2;
            cnt_q   <= k_d;
            err_q   <= (bus.req_instr > 8'd3);
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (instr_q > 8'd3) begin
            state_q <= IDLE;
          end else if (space_ok) begin
            if (cnt_q == 6'd0) begin
              state_q    <= CMD;
              wr_cmd_q   <= 1'b1;
              dout_cmd_q <= cmd_word;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (bus.tok_valid) begin
            wr_data_q   <= 1'b1;
            dout_data_q <= bus.tok_data;
            cnt_q       <= cnt_q - 6'd1;
            // The command write lands in the same cycle as the final token write.
            if (cnt_q == 6'd1) begin
              state_q    <= CMD;
              wr_cmd_q   <= 1'b1;
              dout_cmd_q <= cmd_word;
            end
          end
        end
        CMD: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready        = (state_q == IDLE);
  assign bus.tok_ready        = (state_q == DATA);
  assign bus.busy             = (state_q != IDLE);
  assign bus.wr_en_data       = wr_data_q;
  assign bus.data_out_data    = dout_data_q;
  assign bus.wr_en_command    = wr_cmd_q;
  assign bus.data_out_command = dout_cmd_q;
  assign bus.done             = done_q;
  assign bus.err_opcode       = err_q;

endmodule

// File: tb/tb_command_token_encoder.sv
// Directed bench for command_token_encoder: a vector table of whole instructions plus
// hand-written sequences for FIFO-space stalls and reset in the middle of an instruction.
module tb_command_token_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   t0  = 0;
  int   checks = 0;
  int   errors = 0;

  command_token_encoder_if #(.word_size(16)) bus();

  command_token_encoder #(.word_size(16), .buffer_size(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO-side monitor: every write with the cycle it appeared in
  int dq[$];
  int dcyc[$];
  int cq[$];
  int ccyc[$];
  int done_n, done_cyc, err_n, err_cyc;

  always @(negedge clk) begin
    if (bus.wr_en_data) begin
      dq.push_back(int'(bus.data_out_data));
      dcyc.push_back(cyc);
    end
    if (bus.wr_en_command) begin
      cq.push_back(int'(bus.data_out_command));
      ccyc.push_back(cyc);
    end
    if (bus.done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (bus.err_opcode) begin
      err_n++;
      err_cyc = cyc;
    end
  end

  typedef struct {
    logic [7:0]  instr;
    logic [2:0]  a;
    logic [4:0]  arg2;
    logic [15:0] pop_d;
    logic [15:0] pop_c;
    logic [15:0] base;
    int          supply;
    int          exp_nd;
    logic [15:0] exp_cmd;
    int          exp_ncmd;
    int          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    dq.delete(); dcyc.delete(); cq.delete(); ccyc.delete();
    done_n = 0; done_cyc = 0; err_n = 0; err_cyc = 0;
  endtask

  // Presents a request for one cycle; t0 is set so that the cycle after the accepting edge is 1.
  task automatic issue(input logic [7:0] instr, input logic [2:0] a, input logic [4:0] arg2);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_instr = instr;
    bus.req_a     = a;
    bus.req_arg2  = arg2;
    @(posedge clk);
    #1;
    t0 = cyc - 1;
    bus.req_valid = 1'b0;
  endtask

  // Offers tokens base, base+1, ... with no gaps until req_ready returns; lat is the cycle it does.
  task automatic stream_wait(input logic [15:0] base, input int supply, output int lat);
    int  idx;
    int  n;
    logic rdy;
    idx = 0;
    n   = 0;
    lat = -1;
    while (n < 200) begin
      @(negedge clk);
      if (bus.req_ready) begin
        lat = cyc - t0;
        break;
      end
      rdy = bus.tok_ready;
      bus.tok_valid = (idx < supply);
      bus.tok_data  = base + 16'(idx);
      @(posedge clk);
      if (rdy && bus.tok_valid) idx++;
      n++;
    end
    bus.tok_valid = 1'b0;
    if (lat < 0) begin
      errors++;
      checks++;
      $display("FAIL ready_timeout actual=%0d expected=returned", n);
    end
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    int   lat;
    v = vecs[k];
    clear_mon();
    bus.pop_data    = v.pop_d;
    bus.pop_command = v.pop_c;
    issue(v.instr, v.a, v.arg2);
    stream_wait(v.base, v.supply, lat);
    chk($sformatf("v%0d_latency", k), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("v%0d_ndata", k), 32'(dq.size()), 32'(v.exp_nd));
    for (int i = 0; i < dq.size() && i < v.exp_nd; i++) begin
      chk($sformatf("v%0d_data%0d", k, i), 32'(dq[i]), 32'(v.base + 16'(i)));
      chk($sformatf("v%0d_dcyc%0d", k, i), 32'(dcyc[i] - t0), 32'(3 + i));
    end
    chk($sformatf("v%0d_ncmd", k), 32'(cq.size()), 32'(v.exp_ncmd));
    if (cq.size() > 0 && v.exp_ncmd > 0) begin
      chk($sformatf("v%0d_cmd", k), 32'(cq[0]), 32'(v.exp_cmd));
      chk($sformatf("v%0d_ccyc", k), 32'(ccyc[0] - t0), 32'(v.exp_lat - 2));
    end
    chk($sformatf("v%0d_ndone", k), 32'(done_n), 32'(v.exp_ncmd));
    if (done_n > 0 && v.exp_ncmd > 0)
      chk($sformatf("v%0d_donecyc", k), 32'(done_cyc - t0), 32'(v.exp_lat - 1));
    chk($sformatf("v%0d_nerr", k), 32'(err_n), 32'(v.exp_err));
    if (err_n > 0 && v.exp_err > 0)
      chk($sformatf("v%0d_errcyc", k), 32'(err_cyc - t0), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    //          instr  a     arg2   pop_d    pop_c    base      sup nd  cmd       nc er lat
    vecs[0] = '{8'd0, 3'd2, 5'd3,  16'd0,   16'd0,   16'd5,    4,  4,  16'h1A00, 1, 0, 8};
    vecs[1] = '{8'd1, 3'd1, 5'd4,  16'd0,   16'd0,   16'd9,    2,  1,  16'h2101, 1, 0, 5};
    vecs[2] = '{8'd3, 3'd0, 5'd0,  16'd0,   16'd0,   16'd0,    0,  0,  16'h0003, 1, 0, 4};
    vecs[3] = '{8'd2, 3'd2, 5'd0,  16'd0,   16'd0,   16'd0,    0,  0,  16'h0202, 1, 0, 4};
    vecs[4] = '{8'd2, 3'd5, 5'd3,  16'd1020,16'd0,   16'h1110, 3,  3,  16'h1D02, 1, 0, 7};
    vecs[5] = '{8'd0, 3'd7, 5'd0,  16'd0,   16'd0,   16'hBEEF, 2,  1,  16'h0700, 1, 0, 5};
    vecs[6] = '{8'd3, 3'd7, 5'd31, 16'd0,   16'd1023,16'd0,    0,  0,  16'hFF03, 1, 0, 4};
    vecs[7] = '{8'd0, 3'd2, 5'd31, 16'd992, 16'd0,   16'h0100, 32, 32, 16'hFA00, 1, 0, 36};
    vecs[8] = '{8'd7, 3'd0, 5'd0,  16'd0,   16'd0,   16'd0,    0,  0,  16'h0000, 0, 1, 2};
    vecs[9] = '{8'hFF,3'd3, 5'd5,  16'd0,   16'd0,   16'h4000, 1,  0,  16'h0000, 0, 1, 2};

    bus.req_valid = 1'b0; bus.req_instr = '0; bus.req_a = '0; bus.req_arg2 = '0;
    bus.tok_valid = 1'b0; bus.tok_data = '0; bus.pop_data = '0; bus.pop_command = '0;
    clear_mon();

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_flags", {bus.req_ready, bus.tok_ready, bus.wr_en_data, bus.wr_en_command,
                        bus.busy, bus.done, bus.err_opcode}, 7'b1000000);
    chk("reset_dout_data", bus.data_out_data, 16'h0);
    chk("reset_dout_cmd", bus.data_out_command, 16'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 10; k++) run_vec(k);

    // Data FIFO short by two entries: the instruction must hold in CHECK.
    clear_mon();
    bus.pop_data = 16'd1022;
    bus.pop_command = 16'd0;
    issue(8'd0, 3'd2, 5'd3);
    bus.tok_valid = 1'b1;
    bus.tok_data  = 16'hAAAA;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("stall_data_c%0d", i), {bus.busy, bus.tok_ready, bus.req_ready}, 3'b100);
    end
    chk("stall_data_nowrites", 32'(dq.size() + cq.size()), 32'd0);
    bus.pop_data = 16'd1000;
    stream_wait(16'd5, 4, lat);
    chk("stall_data_ndata", 32'(dq.size()), 32'd4);
    for (int i = 0; i < dq.size() && i < 4; i++)
      chk($sformatf("stall_data_tok%0d", i), 32'(dq[i]), 32'(5 + i));
    chk("stall_data_ncmd", 32'(cq.size()), 32'd1);
    if (cq.size() > 0) chk("stall_data_cmd", 32'(cq[0]), 32'h1A00);
    if (cq.size() > 0 && dcyc.size() == 4)
      chk("stall_data_order", 32'(ccyc[0] >= dcyc[3]), 32'd1);
    bus.pop_data = 16'd0;

    // Command FIFO full blocks even a token-less instruction.
    clear_mon();
    bus.pop_command = 16'd1024;
    issue(8'd3, 3'd1, 5'd0);
    repeat (4) @(negedge clk);
    chk("stall_cmd_busy", {bus.busy, bus.req_ready}, 2'b10);
    chk("stall_cmd_nocmd", 32'(cq.size()), 32'd0);
    bus.pop_command = 16'd1023;
    stream_wait(16'd0, 0, lat);
    chk("stall_cmd_ncmd", 32'(cq.size()), 32'd1);
    if (cq.size() > 0) chk("stall_cmd_cmd", 32'(cq[0]), 32'h0103);
    bus.pop_command = 16'd0;

    // Reset after two of four STP tokens have been written.
    clear_mon();
    issue(8'd0, 3'd2, 5'd3);
    @(negedge clk);
    bus.tok_valid = 1'b1;
    bus.tok_data  = 16'd5;
    @(negedge clk);
    @(negedge clk);
    bus.tok_data  = 16'd6;
    @(negedge clk);
    bus.tok_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_flags", {bus.req_ready, bus.tok_ready, bus.wr_en_data, bus.wr_en_command,
                         bus.busy, bus.done, bus.err_opcode}, 7'b1000000);
    chk("midrst_douts", {bus.data_out_data, bus.data_out_command}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("midrst_ndata", 32'(dq.size()), 32'd2);
    if (dq.size() >= 2) chk("midrst_toks", {dq[0][15:0], dq[1][15:0]}, {16'd5, 16'd6});
    chk("midrst_ncmd", 32'(cq.size()), 32'd0);
    chk("midrst_ndone", 32'(done_n), 32'd0);

    run_vec(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
